// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU control path: opcodes, functs,
// ALU operations, FSM states and datapath mux selects.
package cpu_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [5:0] FUNC_ADD  = 6'b010011;
  localparam logic [5:0] FUNC_SUB  = 6'b010001;
  localparam logic [5:0] FUNC_AND  = 6'b010100;
  localparam logic [5:0] FUNC_OR   = 6'b010110;
  localparam logic [5:0] FUNC_SLT  = 6'b110000;
  localparam logic [5:0] FUNC_NOR  = 6'b010101;
  localparam logic [5:0] FUNC_SLL  = 6'b000000;
  localparam logic [5:0] FUNC_SRL  = 6'b000010;
  localparam logic [5:0] FUNC_SLLV = 6'b000110;
  localparam logic [5:0] FUNC_SRLV = 6'b000100;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SLLV = 4'b1010;
  localparam logic [3:0] ALU_SRLV = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  // Four bits wide so that unused encodings exist and can be steered back to FETCH.
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXEC_R = 4'd2,
    EXEC_I = 4'd3,
    WB_R   = 4'd4,
    WB_I   = 4'd5,
    BRANCH = 4'd6,
    TRAP   = 4'd7
  } state_e;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_REG   = 2'd1;
  localparam logic [1:0] SRCA_SHAMT = 2'd2;

  localparam logic [2:0] SRCB_REG      = 3'd0;
  localparam logic [2:0] SRCB_FOUR     = 3'd1;
  localparam logic [2:0] SRCB_SIMM     = 3'd2;
  localparam logic [2:0] SRCB_SIMM_SH2 = 3'd3;
  localparam logic [2:0] SRCB_ZIMM     = 3'd4;
  localparam logic [2:0] SRCB_IMM_HI   = 3'd5;

endpackage

// File: rtl/alu_decoder.sv
// Combinational R-type funct decoder: ALU operation plus a flag saying
// whether the funct is one the datapath implements.
module alu_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [3:0] alu_ctrl_o,
  output logic       legal_o
);

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    legal_o    = 1'b1;
    case (funct_i)
      FUNC_ADD:  alu_ctrl_o = ALU_ADD;
      FUNC_SUB:  alu_ctrl_o = ALU_SUB;
      FUNC_AND:  alu_ctrl_o = ALU_AND;
      FUNC_OR:   alu_ctrl_o = ALU_OR;
      FUNC_SLT:  alu_ctrl_o = ALU_SLT;
      FUNC_NOR:  alu_ctrl_o = ALU_NOR;
      FUNC_SLL:  alu_ctrl_o = ALU_SLL;
      FUNC_SRL:  alu_ctrl_o = ALU_SRL;
      FUNC_SLLV: alu_ctrl_o = ALU_SLLV;
      FUNC_SRLV: alu_ctrl_o = ALU_SRLV;
      default:   legal_o    = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for the shared-ALU multi-cycle datapath: sequences fetch,
// decode, execute and writeback, and keeps cycle / retired-instruction counts.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int STATE_W = 4
) (
  input  logic               clk_i,
  input  logic               rst_n,
  input  logic [5:0]         opcode_i,
  input  logic [5:0]         funct_i,
  input  logic               zero_i,
  input  logic               imem_ack_i,
  output logic               imem_req_o,
  output logic               ir_write_o,
  output logic               pc_write_o,
  output logic               pc_src_o,
  output logic [1:0]         alu_src_a_o,
  output logic [2:0]         alu_src_b_o,
  output logic [3:0]         alu_ctrl_o,
  output logic               reg_write_o,
  output logic               reg_dst_o,
  output logic               trap_o,
  output logic [STATE_W-1:0] state_o,
  output logic [CNT_W-1:0]   cycle_cnt_o,
  output logic [CNT_W-1:0]   instret_o
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cycleCnt_q, instret_q;
  logic [3:0]        decAlu;
  logic              decLegal;
  logic              irWrite, pcWrite, regWrite, trapFlag, retire;

  alu_decoder u_alu_decoder (
    .funct_i    (funct_i),
    .alu_ctrl_o (decAlu),
    .legal_o    (decLegal)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      cycleCnt_q <= '0;
      instret_q  <= '0;
    end else begin
      state_q    <= state_d;
      cycleCnt_q <= cycleCnt_q + CNT_W'(1);
      if (retire) instret_q <= instret_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    imem_req_o  = 1'b0;
    irWrite     = 1'b0;
    pcWrite     = 1'b0;
    pc_src_o    = 1'b0;
    alu_src_a_o = SRCA_PC;
    alu_src_b_o = SRCB_REG;
    alu_ctrl_o  = ALU_ADD;
    regWrite    = 1'b0;
    reg_dst_o   = 1'b0;
    trapFlag    = 1'b0;
    retire      = 1'b0;
    case (state_q)
      FETCH: begin
        imem_req_o  = 1'b1;
        alu_src_b_o = SRCB_FOUR;
        if (imem_ack_i) begin
          irWrite = 1'b1;
          pcWrite = 1'b1;
          state_d = DECODE;
        end
      end
      // Branch target is computed speculatively here so BRANCH only needs the compare.
      DECODE: begin
        alu_src_b_o = SRCB_SIMM_SH2;
        case (opcode_i)
          OP_RTYPE:               state_d = decLegal ? EXEC_R : TRAP;
          OP_ADDI, OP_ORI, OP_LUI: state_d = EXEC_I;
          OP_BEQ:                 state_d = BRANCH;
          default:                state_d = TRAP;
        endcase
      end
      EXEC_R: begin
        alu_src_a_o = (decAlu == ALU_SLL || decAlu == ALU_SRL) ? SRCA_SHAMT : SRCA_REG;
        alu_ctrl_o  = decAlu;
        state_d     = WB_R;
      end
      EXEC_I: begin
        alu_src_a_o = SRCA_REG;
        case (opcode_i)
          OP_ORI: begin
            alu_src_b_o = SRCB_ZIMM;
            alu_ctrl_o  = ALU_OR;
          end
          OP_LUI:  alu_src_b_o = SRCB_IMM_HI;
          default: alu_src_b_o = SRCB_SIMM;
        endcase
        state_d = WB_I;
      end
      WB_R: begin
        regWrite  = 1'b1;
        reg_dst_o = 1'b1;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      WB_I: begin
        regWrite = 1'b1;
        retire   = 1'b1;
        state_d  = FETCH;
      end
      BRANCH: begin
        alu_src_a_o = SRCA_REG;
        alu_ctrl_o  = ALU_SUB;
        pc_src_o    = 1'b1;
        pcWrite     = zero_i;
        retire      = 1'b1;
        state_d     = FETCH;
      end
      TRAP: begin
        trapFlag = 1'b1;
        state_d  = TRAP;
      end
      default: state_d = FETCH;
    endcase
  end

  // Reset masks every write strobe and the trap flag immediately, whatever state is held.
  assign ir_write_o  = irWrite  & rst_n;
  assign pc_write_o  = pcWrite  & rst_n;
  assign reg_write_o = regWrite & rst_n;
  assign trap_o      = trapFlag & rst_n;
  assign state_o     = STATE_W'(state_q);
  assign cycle_cnt_o = cycleCnt_q;
  assign instret_o   = instret_q;

endmodule
